uart_gpio_periph: RTL and testbench

- Memory-mapped peripheral block combining a 32-bit GPIO register file with a transmit-only 8N1 UART emitter.
- Sits on the CPU's simple valid/write-enable bus behind the SoC address decoder.
- The SoC drives LEDs from gpio_out[4:0] and console characters through o_uart_tx.

---
 rtl/uart_gpio_periph.sv | 201 ++++++++++++++++++++
 tb/tb_uart_gpio_periph.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_gpio_periph.sv
// uart_gpio_periph: memory-mapped GPIO register file plus a transmit-only
// 8N1 UART, on a simple valid/write-enable bus with registered read data.
// Optional build macro GPIO_IN_SYNC_EN adds a two-flop synchronizer on gpio_in
// ahead of the GPIO_IN read mux; without it pins are read directly.
module uart_gpio_periph #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_oe,
  output logic        o_uart_tx,
  output logic        o_uart_ready
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  localparam logic [2:0] A_GPIO_DATA = 3'd0;
  localparam logic [2:0] A_GPIO_DIR  = 3'd1;
  localparam logic [2:0] A_GPIO_IN   = 3'd2;
  localparam logic [2:0] A_UART_DATA = 3'd3;
  localparam logic [2:0] A_UART_STAT = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [31:0]      gpio_out_q, gpio_out_d;
  logic [31:0]      gpio_oe_q, gpio_oe_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [31:0]      gpio_in_view;

  logic       wr_en;
  logic       rd_en;
  logic [2:0] sel;
  logic       bit_end;
  logic       unused_addr_bits;

  assign wr_en   = bus_valid & bus_we;
  assign rd_en   = bus_valid & ~bus_we;
  assign sel     = bus_addr[4:2];
  assign bit_end = (cnt_q == CNT_LAST);
  assign unused_addr_bits = ^{bus_addr[31:5], bus_addr[1:0]};

`ifdef GPIO_IN_SYNC_EN
  logic [31:0] sync1_q, sync1_d;
  logic [31:0] sync2_q, sync2_d;

  // Two-stage synchronizer chain for the asynchronous input pins.
  always_comb begin
    sync1_d = gpio_in;
    sync2_d = sync1_q;
  end

  // Synchronizer flops, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign gpio_in_view = sync2_q;
`else
  assign gpio_in_view = gpio_in;
`endif

  // Next-state logic: register writes, read mux and UART transmit FSM.
  always_comb begin
    gpio_out_d = gpio_out_q;
    gpio_oe_d  = gpio_oe_q;
    rdata_d    = rdata_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;

    if (wr_en) begin
      case (sel)
        A_GPIO_DATA: gpio_out_d = bus_wdata;
        A_GPIO_DIR:  gpio_oe_d  = bus_wdata;
        default:     ;
      endcase
    end

    if (rd_en) begin
      case (sel)
        A_GPIO_DATA: rdata_d = gpio_out_q;
        A_GPIO_DIR:  rdata_d = gpio_oe_q;
        A_GPIO_IN:   rdata_d = gpio_in_view;
        A_UART_STAT: rdata_d = {22'd0, ~ready_q, 9'd0};
        default:     rdata_d = 32'd0;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (wr_en && (sel == A_UART_DATA) && ready_q) begin
          shift_d = bus_wdata[7:0];
          state_d = ST_START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[idx_d];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  // State registers; reset also aborts any frame in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gpio_out_q <= '0;
      gpio_oe_q  <= '0;
      rdata_q    <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      gpio_oe_q  <= gpio_oe_d;
      rdata_q    <= rdata_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
    end
  end

  assign bus_rdata    = rdata_q;
  assign gpio_out     = gpio_out_q;
  assign gpio_oe      = gpio_oe_q;
  assign o_uart_tx    = tx_q;
  assign o_uart_ready = ready_q;

endmodule

// File: tb/tb_uart_gpio_periph.sv
// tb_uart_gpio_periph: directed self-checking bench for uart_gpio_periph,
// built with a 4-cycle bit period so whole UART frames stay short.
module tb_uart_gpio_periph;

  localparam int DIV = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        o_uart_tx;
  logic        o_uart_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_gpio_periph #(
    .CLK_FREQ_HZ(12000000),
    .BAUD_RATE  (3000000)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus_valid   (bus_valid),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe),
    .o_uart_tx   (o_uart_tx),
    .o_uart_ready(o_uart_ready)
  );

  // 10 ns system clock.
  always #5 i_clk = ~i_clk;

  // One-cycle write strobe; returns 1 ns after the updating edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge i_clk);
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    @(posedge i_clk);
    #1;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
  endtask

  // One-cycle read strobe; data is taken 1 ns after the strobe edge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge i_clk);
    bus_valid = 1'b1;
    bus_we    = 1'b0;
    bus_addr  = a;
    @(posedge i_clk);
    #1;
    bus_valid = 1'b0;
    d = bus_rdata;
  endtask

  // Reset values and an initial status read.
  task automatic test_reset();
    logic [31:0] d;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    tests_run++;
    if (gpio_out !== 32'd0 || gpio_oe !== 32'd0 || bus_rdata !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs: got out=%h oe=%h rdata=%h, expected all 0", gpio_out, gpio_oe, bus_rdata);
    end
    tests_run++;
    if (o_uart_tx !== 1'b1 || o_uart_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_uart: got tx=%b ready=%b, expected 1 1", o_uart_tx, o_uart_ready);
    end
    i_rst = 1'b0;
    bus_read(32'h10, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got %h expected 00000000", d);
    end
  endtask

  // GPIO data/direction registers, unmasked output and ignored offsets.
  task automatic test_gpio_regs();
    logic [31:0] d;
    bus_write(32'h00, 32'h0000001F);
    tests_run++;
    if (gpio_out !== 32'h1F) begin
      tests_failed++;
      $display("[TB] FAIL gpio_out_write: got %h expected 0000001f", gpio_out);
    end
    bus_write(32'h04, 32'h000000FF);
    tests_run++;
    if (gpio_oe !== 32'hFF) begin
      tests_failed++;
      $display("[TB] FAIL gpio_oe_write: got %h expected 000000ff", gpio_oe);
    end
    bus_read(32'h00, d);
    tests_run++;
    if (d !== 32'h1F) begin
      tests_failed++;
      $display("[TB] FAIL gpio_data_read: got %h expected 0000001f", d);
    end
    bus_read(32'h04, d);
    tests_run++;
    if (d !== 32'hFF) begin
      tests_failed++;
      $display("[TB] FAIL gpio_dir_read: got %h expected 000000ff", d);
    end
    repeat (3) @(posedge i_clk);
    #1;
    tests_run++;
    if (bus_rdata !== 32'hFF) begin
      tests_failed++;
      $display("[TB] FAIL rdata_hold: got %h expected 000000ff", bus_rdata);
    end
    bus_write(32'h1C, 32'hDEADBEEF);
    bus_write(32'h10, 32'hDEADBEEF);
    tests_run++;
    if (gpio_out !== 32'h1F || gpio_oe !== 32'hFF) begin
      tests_failed++;
      $display("[TB] FAIL ignored_write: got out=%h oe=%h expected 0000001f 000000ff", gpio_out, gpio_oe);
    end
    bus_read(32'h14, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL unmapped_read: got %h expected 00000000", d);
    end
    bus_write(32'h00, 32'hFFFF0000);
    tests_run++;
    if (gpio_out !== 32'hFFFF0000) begin
      tests_failed++;
      $display("[TB] FAIL gpio_unmasked: got %h expected ffff0000", gpio_out);
    end
  endtask

  // GPIO_IN reads after settle time; RO write has no effect.
  task automatic test_gpio_in();
    logic [31:0] d;
    gpio_in = 32'hA5A5A5A5;
    repeat (3) @(posedge i_clk);
    bus_read(32'h08, d);
    tests_run++;
    if (d !== 32'hA5A5A5A5) begin
      tests_failed++;
      $display("[TB] FAIL gpio_in_a5: got %h expected a5a5a5a5", d);
    end
    bus_write(32'h08, 32'h00000000);
    gpio_in = 32'h5A5A0F0F;
    repeat (3) @(posedge i_clk);
    bus_read(32'h08, d);
    tests_run++;
    if (d !== 32'h5A5A0F0F) begin
      tests_failed++;
      $display("[TB] FAIL gpio_in_5a: got %h expected 5a5a0f0f", d);
    end
    bus_read(32'h0C, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL uart_data_read: got %h expected 00000000", d);
    end
  endtask

  // Sends byte b and checks every cycle of the frame plus a quiet tail.
  // If inj_k >= 0, a UART_DATA write of inj_b is driven onto the edge
  // that follows frame cycle inj_k; it must be dropped.
  task automatic test_uart_frame(input logic [7:0] b, input int inj_k, input logic [7:0] inj_b);
    logic [9:0] frame;
    int         bad;
    frame = {1'b1, b, 1'b0};
    bus_write(32'h0C, {24'd0, b});
    for (int k = 0; k < 10 * DIV; k++) begin
      tests_run++;
      if (o_uart_tx !== frame[k / DIV] || o_uart_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL frame_cycle_%0d: got tx=%b ready=%b expected tx=%b ready=0", k, o_uart_tx, o_uart_ready, frame[k / DIV]);
      end
      if (k == inj_k) begin
        bus_valid = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = 32'h0C;
        bus_wdata = {24'd0, inj_b};
      end
      @(posedge i_clk);
      #1;
      bus_valid = 1'b0;
      bus_we    = 1'b0;
    end
    tests_run++;
    if (o_uart_tx !== 1'b1 || o_uart_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL frame_end: got tx=%b ready=%b expected 1 1", o_uart_tx, o_uart_ready);
    end
    bad = 0;
    for (int k = 0; k < 11 * DIV; k++) begin
      if (o_uart_tx !== 1'b1 || o_uart_ready !== 1'b1) bad++;
      @(posedge i_clk);
      #1;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL no_second_frame: got %0d active cycles expected 0", bad);
    end
  endtask

  // Status bit9 while busy and after the frame completes.
  task automatic test_status();
    logic [31:0] d;
    int          n;
    bus_write(32'h0C, 32'h00000055);
    repeat (2) @(posedge i_clk);
    bus_read(32'h10, d);
    tests_run++;
    if (d !== 32'h00000200) begin
      tests_failed++;
      $display("[TB] FAIL status_busy: got %h expected 00000200", d);
    end
    n = 0;
    while (o_uart_ready !== 1'b1 && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    tests_run++;
    if (n >= 100) begin
      tests_failed++;
      $display("[TB] FAIL status_timeout: got ready=%b after %0d cycles expected 1", o_uart_ready, n);
    end
    bus_read(32'h10, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL status_idle: got %h expected 00000000", d);
    end
  endtask

  // Reset during DATA bit 3 aborts the frame and clears GPIO registers.
  task automatic test_mid_frame_reset();
    bus_write(32'h04, 32'h000000FF);
    bus_write(32'h0C, 32'h00000041);
    repeat (18) @(posedge i_clk);
    #1;
    tests_run++;
    if (o_uart_tx !== 1'b0 || o_uart_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL pre_abort: got tx=%b ready=%b expected 0 0", o_uart_tx, o_uart_ready);
    end
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    tests_run++;
    if (o_uart_tx !== 1'b1 || o_uart_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_uart: got tx=%b ready=%b expected 1 1", o_uart_tx, o_uart_ready);
    end
    tests_run++;
    if (gpio_out !== 32'd0 || gpio_oe !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_gpio: got out=%h oe=%h expected 0 0", gpio_out, gpio_oe);
    end
    test_uart_frame(8'h41, -1, 8'h00);
  endtask

  initial begin
    i_rst     = 1'b1;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    gpio_in   = 32'd0;
    test_reset();
    test_gpio_regs();
    test_gpio_in();
    test_uart_frame(8'h41, -1, 8'h00);
    test_uart_frame(8'h41, 10, 8'h42);
    test_uart_frame(8'hA3, 10 * DIV - 1, 8'h42);
    test_status();
    test_mid_frame_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
